// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: FSM states, register offsets, STATUS layout.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic [2:0] OFS_TXDATA = 3'h0;
   localparam logic [2:0] OFS_STATUS = 3'h4;

   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_BUSY    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 8;

   function automatic logic [31:0] build_status(input logic full, input logic empty,
                                                input logic busy, input logic ovf,
                                                input logic [7:0] count);
      logic [31:0] s;
      s = '0;
      s[STAT_FULL]                   = full;
      s[STAT_EMPTY]                  = empty;
      s[STAT_BUSY]                   = busy;
      s[STAT_OVF]                    = ovf;
      s[STAT_CNT_LSB +: 8]           = count;
      return s;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART transmitter; power-of-two depth, pointers wrap naturally.
module uart_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   // A push on a full FIFO is discarded even when a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, TX FIFO and 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        sel,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        irq
);
   localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   uart_state_e   state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          ovf_q, ovf_d;
   logic [2:0]    reg_ofs;
   logic          wr_txdata, wr_status, busy;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          unused_bits;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   assign sel         = (addr[31:3] == BASE_ADDR[31:3]);
   assign reg_ofs     = {addr[2], 2'b00};
   assign wr_txdata   = MemWrite && sel && (reg_ofs == OFS_TXDATA);
   assign wr_status   = MemWrite && sel && (reg_ofs == OFS_STATUS);
   assign unused_bits = ^{addr[1:0], wdata[31:8]};

   uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_txdata),
      .pop   (fifo_pop),
      .din   (wdata[7:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Overflow is applied after the clear so a coincident overflow keeps ovf set.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_status && wdata[STAT_OVF]) ovf_d = 1'b0;
      if (wr_txdata && fifo_full)       ovf_d = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d    = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d  = START;
               fifo_pop = 1'b1;
               shreg_d  = fifo_dout;
               cnt_d    = BIT_LAST;
               bit_d    = '0;
`ifdef UART_TX_PARITY_EN
               par_d    = ^fifo_dout;
`endif
            end
         end
         START: begin
            if (cnt_q == '0) begin
               state_d = DATA;
               cnt_d   = BIT_LAST;
            end else begin
               cnt_d   = cnt_q - 16'd1;
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               cnt_d   = BIT_LAST;
               shreg_d = {1'b0, shreg_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (cnt_q == '0) begin
               state_d = STOP;
               cnt_d   = BIT_LAST;
            end else begin
               cnt_d   = cnt_q - 16'd1;
            end
         end
`endif
         STOP: begin
            if (cnt_q == '0) begin
               cnt_d = BIT_LAST;
               // Chain straight into the next frame so back-to-back bytes leave no idle gap.
               if (!fifo_empty) begin
                  state_d  = START;
                  fifo_pop = 1'b1;
                  shreg_d  = fifo_dout;
                  bit_d    = '0;
`ifdef UART_TX_PARITY_EN
                  par_d    = ^fifo_dout;
`endif
               end else begin
                  state_d  = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx = par_q;
`endif
         default: tx = 1'b1;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign irq   = fifo_empty && !busy;
   assign rdata = (sel && reg_ofs == OFS_STATUS)
                  ? build_status(fifo_full, fifo_empty, busy, ovf_q, 8'(fifo_count))
                  : 32'h0;

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, is the number of clk cycles per serial bit; legal range is 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, is the number of TX FIFO entries; it SHALL be a power of two from 2 to 64.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0100, is the word-aligned base of the register window.
REQ-004 clk  in  1  is the CPU clock; all state is updated on the rising edge.
REQ-005 rst  in  1  is the reset: synchronous and active-high.
REQ-006 MemWrite  in  1  is the CPU store strobe (same timing as the data-memory write enable).
REQ-007 addr  in  32  is the CPU data address (ALU output).
REQ-008 wdata  in  32  is the CPU store data.
REQ-009 sel  out  1  is high combinationally when addr falls in BASE_ADDR..BASE_ADDR+7; the top level uses it to mux read data and to block the dm write.
REQ-010 rdata  out  32  is the combinational register read data.
REQ-011 tx  out  1  is the serial line, idle high.
REQ-012 irq  out  1  is high while the FIFO is empty and the transmitter is idle.

Function
REQ-013 TXDATA is at offset 0x0; a store with sel high pushes wdata[7:0] into the FIFO at the clk edge; wdata[31:8] is ignored.
REQ-014 STATUS is at offset 0x4 and is read-only except for bit3; its fields are: bit0 full, bit1 empty, bit2 busy, bit3 ovf (sticky), bits[15:8] count; all other bits read 0.
REQ-015 Reads of TXDATA SHALL return 0; there are no read side effects.
REQ-016 A push while the FIFO is full SHALL be dropped and SHALL set ovf, even if a pop occurs in the same cycle.
REQ-017 A store to STATUS with wdata[3]=1 SHALL clear ovf; if it coincides with a new overflow, the overflow wins (ovf stays set).
REQ-018 The FSM states are IDLE, START, DATA, STOP (plus PARITY, see REQ-028).
REQ-019 IDLE → START when the FIFO is non-empty; the head byte is popped into the shift register on that edge, and tx=0 from the next cycle.
REQ-020 Each of START, DATA (8 bits, LSB first), PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads on every state change.
REQ-021 STOP drives tx=1; at the end of STOP the FSM goes to START if the FIFO is non-empty (back-to-back frames with no idle gap), otherwise to IDLE.
REQ-022 Latency: a push at edge N into an empty FIFO with the FSM in IDLE SHALL give tx falling after edge N+1.
REQ-023 busy is 1 in every state except IDLE.
REQ-024 count is the number of entries held (0..FIFO_DEPTH); full is count==FIFO_DEPTH and empty is count==0; the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-025 A simultaneous push and pop on a non-full FIFO SHALL leave count unchanged.

Reset
REQ-026 While rst is high at an edge, the block SHALL set FSM=IDLE, FIFO empty, ovf=0, shift register=0 and bit counter=0.
REQ-027 Outputs after reset: tx=1, irq=1, rdata from STATUS = 32'h0000_0002; a reset in mid-frame SHALL abort the frame and drive tx=1 on the following cycle.

Configuration
REQ-028 Defining UART_TX_PARITY_EN SHALL insert the PARITY state between DATA and STOP, transmitting even parity (XOR of the 8 data bits); without the macro there is no PARITY state and no parity logic, giving a 10-bit frame.

Structure
REQ-029 The shared package uart_pkg SHALL hold the FSM state enum, the register offsets (OFS_TXDATA=0, OFS_STATUS=4) and the STATUS bit-index constants.
REQ-030 The FIFO SHALL be a separate sub-module, uart_fifo (parameter DEPTH; ports push, pop, din, dout, count, full, empty), with synchronous reset.

Verification
REQ-031 Scenario 1: reset, then store 0x55 to BASE_ADDR with CLKS_PER_BIT=4 -> tx low from edge 2; frame 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles; irq returns high 40 cycles after tx falls.
REQ-032 Scenario 2: push 9 bytes 0x01..0x09 back-to-back with FIFO_DEPTH=8 while the FSM is in IDLE -> the first byte is popped; all 9 bytes are sent with ovf=0; a 10th push while count=8 sets ovf=1 and 0x0A is never sent.
REQ-033 Scenario 3: push 0xA3 and 0x3C on consecutive cycles -> two frames with no idle high gap between the stop bit and the next start bit.
REQ-034 Scenario 4: read STATUS during a frame with 3 bytes queued -> 32'h0000_0304 (count=3, busy=1); after draining -> 32'h0000_0002; a write of 32'h8 to BASE+4 clears ovf.
REQ-035 Scenario 5: assert rst at the 3rd data bit of frame 0xFF -> tx=1, count=0, FSM IDLE on the next cycle; no residual frame follows.
REQ-036 Scenario 6 (UART_TX_PARITY_EN): send 0x07 -> parity bit 1 then stop bit; send 0x03 -> parity bit 0; each frame is 11 bits.
